// File: rtl/ge_pkg.sv
// Shared types for the temporal GE comparator array: comparison modes,
// channel FSM states and the cmp_mode decoder.
package ge_pkg;

  typedef enum logic [1:0] {
    CMP_GE = 2'd0,
    CMP_GT = 2'd1,
    CMP_EQ = 2'd2
  } cmp_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    B_SEEN = 2'd1,
    FIRE   = 2'd2,
    DONE   = 2'd3
  } ch_state_e;

  // The unused encoding 2'b11 is folded onto GE so the mode register
  // never holds an undefined relation.
  function automatic cmp_mode_e decode_cmp_mode(input logic [1:0] raw);
    cmp_mode_e mode;
    case (raw)
      2'b01:   mode = CMP_GT;
      2'b10:   mode = CMP_EQ;
      default: mode = CMP_GE;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/ge_channel.sv
// One race-logic comparator channel: tracks first arrivals of a and b within
// the current gamma cycle and emits a PULSE_WIDTH-cycle pulse on q when the
// selected relation holds. With GE_TIMESTAMP_EN defined, the gcnt value of
// a's arrival is latched into t_out when the pulse starts.
module ge_channel
  import ge_pkg::*;
#(
`ifdef GE_TIMESTAMP_EN
  parameter int GAMMA_CYCLE_WIDTH = 16,
`endif
  parameter int PULSE_WIDTH = 8
) (
  input  logic      aclk,
  input  logic      grst,
  input  logic      a,
  input  logic      b,
  input  logic      boundary,
  input  cmp_mode_e mode_q,
`ifdef GE_TIMESTAMP_EN
  input  logic [GAMMA_CYCLE_WIDTH-1:0] gcnt,
  output logic [GAMMA_CYCLE_WIDTH-1:0] t_out,
`endif
  output logic      q,
  output logic      fired
);

  localparam int PCW = $clog2(PULSE_WIDTH + 1);
  localparam logic [PCW-1:0] PCNT_LAST = PCW'(PULSE_WIDTH);

  ch_state_e      state_r;
  ch_state_e      state_nxt_s;
  logic [PCW-1:0] pcnt_r;
  logic [PCW-1:0] pcnt_nxt_s;
  logic           fire_entry_s;
  logic           q_r;
  logic           fired_r;

  // Next-state logic; the gamma boundary overrides every event so inputs in
  // the last cycle of a gamma are never recorded.
  always_comb begin
    state_nxt_s  = state_r;
    pcnt_nxt_s   = pcnt_r;
    fire_entry_s = 1'b0;
    if (boundary) begin
      state_nxt_s = IDLE;
      pcnt_nxt_s  = PCW'(0);
    end else begin
      case (state_r)
        IDLE: begin
          if (a && b) begin
            if (mode_q == CMP_GT) begin
              state_nxt_s = DONE;
            end else begin
              state_nxt_s  = FIRE;
              fire_entry_s = 1'b1;
            end
          end else if (a) begin
            state_nxt_s = DONE;
          end else if (b) begin
            state_nxt_s = B_SEEN;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        B_SEEN: begin
          if (a) begin
            if (mode_q == CMP_EQ) begin
              state_nxt_s = DONE;
            end else begin
              state_nxt_s  = FIRE;
              fire_entry_s = 1'b1;
            end
          end else begin
            state_nxt_s = B_SEEN;
          end
        end
        FIRE: begin
          if (pcnt_r == PCNT_LAST) begin
            state_nxt_s = DONE;
            pcnt_nxt_s  = PCW'(0);
          end else begin
            pcnt_nxt_s = pcnt_r + PCW'(1);
          end
        end
        DONE: begin
          state_nxt_s = DONE;
        end
        default: begin
          state_nxt_s = IDLE;
          pcnt_nxt_s  = PCW'(0);
        end
      endcase
      if (fire_entry_s) begin
        pcnt_nxt_s = PCW'(1);
      end else begin
        pcnt_nxt_s = pcnt_nxt_s;
      end
    end
  end

  // State, pulse counter, registered pulse output and sticky fired flag.
  always_ff @(posedge aclk) begin
    if (grst) begin
      state_r <= IDLE;
      pcnt_r  <= PCW'(0);
      q_r     <= 1'b0;
      fired_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pcnt_r  <= pcnt_nxt_s;
      q_r     <= (state_nxt_s == FIRE);
      fired_r <= boundary ? 1'b0 : (fired_r | fire_entry_s);
    end
  end

`ifdef GE_TIMESTAMP_EN
  logic [GAMMA_CYCLE_WIDTH-1:0] t_r;

  // Arrival timestamp of a, captured as the pulse starts, cleared each gamma.
  always_ff @(posedge aclk) begin
    if (grst) begin
      t_r <= GAMMA_CYCLE_WIDTH'(0);
    end else if (boundary) begin
      t_r <= GAMMA_CYCLE_WIDTH'(0);
    end else if (fire_entry_s) begin
      t_r <= gcnt;
    end else begin
      t_r <= t_r;
    end
  end

  assign t_out = t_r;
`endif

  assign q     = q_r;
  assign fired = fired_r;

endmodule

// File: rtl/temporal_ge_array.sv
// N-channel race-logic temporal comparator with built-in gamma timer.
// Optional macro GE_TIMESTAMP_EN adds the per-channel t_out timestamp port.
module temporal_ge_array
  import ge_pkg::*;
#(
  parameter int N_CH              = 8,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int GAMMA_PERIOD      = 256,
  parameter int PULSE_WIDTH       = 8
) (
  input  logic            aclk,
  input  logic            grst,
  input  logic [N_CH-1:0] a,
  input  logic [N_CH-1:0] b,
  input  logic [1:0]      cmp_mode,
`ifdef GE_TIMESTAMP_EN
  output logic [N_CH-1:0][GAMMA_CYCLE_WIDTH-1:0] t_out,
`endif
  output logic [N_CH-1:0] q,
  output logic [N_CH-1:0] fired,
  output logic            gamma_start
);

  localparam logic [GAMMA_CYCLE_WIDTH-1:0] GCNT_LAST =
    GAMMA_CYCLE_WIDTH'(GAMMA_PERIOD - 1);

  logic [GAMMA_CYCLE_WIDTH-1:0] gcnt_r;
  cmp_mode_e                    mode_q_r;
  logic                         boundary_s;

  assign boundary_s  = (gcnt_r == GCNT_LAST);
  assign gamma_start = (gcnt_r == GAMMA_CYCLE_WIDTH'(0));

  // Gamma counter wrapping at GAMMA_PERIOD; mode is latched only at the
  // boundary so mid-gamma cmp_mode changes wait for the next gamma.
  always_ff @(posedge aclk) begin
    if (grst) begin
      gcnt_r   <= GAMMA_CYCLE_WIDTH'(0);
      mode_q_r <= CMP_GE;
    end else if (boundary_s) begin
      gcnt_r   <= GAMMA_CYCLE_WIDTH'(0);
      mode_q_r <= decode_cmp_mode(cmp_mode);
    end else begin
      gcnt_r   <= gcnt_r + GAMMA_CYCLE_WIDTH'(1);
      mode_q_r <= mode_q_r;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ge_channel #(
`ifdef GE_TIMESTAMP_EN
      .GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH),
`endif
      .PULSE_WIDTH(PULSE_WIDTH)
    ) u_ch (
      .aclk    (aclk),
      .grst    (grst),
      .a       (a[i]),
      .b       (b[i]),
      .boundary(boundary_s),
      .mode_q  (mode_q_r),
`ifdef GE_TIMESTAMP_EN
      .gcnt    (gcnt_r),
      .t_out   (t_out[i]),
`endif
      .q       (q[i]),
      .fired   (fired[i])
    );
  end

endmodule
